// File: rtl/axi4_pl_irq_seq_pkg.sv
// Shared types and constants for the PL interrupt sequencer.
// Provides the FSM state encoding and the pulse/level mode codes.
package axi4_pl_irq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FIRE,
    ST_ACK_WAIT,
    ST_DONE
  } state_e;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

endpackage

// File: rtl/axi4_pl_irq_seq_timer.sv
// Loadable unsigned down-counter that paces the gap before each interrupt fire.
// It saturates at zero, so an extra dec never wraps the count.
module axi4_pl_irq_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/axi4_pl_irq_sequencer.sv
// Fires a configurable set of PL->PS interrupt lines a programmed number of
// times, with an idle gap before each fire, in pulse or level (ack) mode.
module axi4_pl_irq_sequencer
  import axi4_pl_irq_seq_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int CNT_W   = 32
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_IRQ-1:0] cfg_mask,
  input  logic [CNT_W-1:0]   cfg_delay,
  input  logic [7:0]         cfg_repeat,
  input  logic               cfg_level,
  input  logic [NUM_IRQ-1:0] irq_ack,
  output logic [NUM_IRQ-1:0] irq,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [8:0]         fire_cnt
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [7:0]         rep_q, rep_d;
  logic               level_q, level_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [8:0]         fire_cnt_q, fire_cnt_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;
  logic [NUM_IRQ-1:0] irq_nxt;

  axi4_pl_irq_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    delay_d    = delay_q;
    rep_d      = rep_q;
    level_d    = level_q;
    irq_d      = irq_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fire_cnt_d = fire_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = delay_q;
    tmr_dec    = 1'b0;
    // Pulse mode drops the lines after one cycle; level mode waits for acks.
    irq_nxt    = (level_q == MODE_LEVEL) ? (irq_q & ~irq_ack) : '0;

    if (abort) begin
      state_d = ST_IDLE;
      irq_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_mask != '0) begin
              mask_d     = cfg_mask;
              delay_d    = cfg_delay;
              rep_d      = cfg_repeat;
              level_d    = cfg_level;
              tmr_load   = 1'b1;
              tmr_val    = cfg_delay;
              fire_cnt_d = '0;
              state_d    = ST_WAIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (tmr_zero) begin
            irq_d      = mask_q;
            fire_cnt_d = fire_cnt_q + 9'd1;
            state_d    = ST_FIRE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_FIRE, ST_ACK_WAIT: begin
          irq_d = irq_nxt;
          if (irq_nxt == '0) begin
            if (rep_q != 8'd0) begin
              rep_d    = rep_q - 8'd1;
              tmr_load = 1'b1;
              state_d  = ST_WAIT;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_ACK_WAIT;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          irq_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      delay_q    <= '0;
      rep_q      <= '0;
      level_q    <= MODE_PULSE;
      irq_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fire_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      delay_q    <= delay_d;
      rep_q      <= rep_d;
      level_q    <= level_d;
      irq_q      <= irq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign irq      = irq_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign fire_cnt = fire_cnt_q;

endmodule

// File: tb/tb_axi4_pl_irq_sequencer.sv
// Scoreboard bench for the interrupt sequencer: the driver predicts a timeline of
// output events per run, a negedge monitor pops and compares each observed event.
module tb_axi4_pl_irq_sequencer;

  localparam int EV_IRQ  = 0;
  localparam int EV_BUSY = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int     kind;
    longint cyc;
    int     val;
  } ev_t;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_mask = '0;
  logic [31:0] cfg_delay = '0;
  logic [7:0]  cfg_repeat = '0;
  logic        cfg_level = 1'b0;
  logic [15:0] irq_ack = '0;
  logic [15:0] irq;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  fire_cnt;

  longint cyc = 0;
  ev_t    exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  bit     end_req = 1'b0;

  axi4_pl_irq_sequencer #(
    .NUM_IRQ (16),
    .CNT_W   (32)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .start      (start),
    .abort      (abort),
    .cfg_mask   (cfg_mask),
    .cfg_delay  (cfg_delay),
    .cfg_repeat (cfg_repeat),
    .cfg_level  (cfg_level),
    .irq_ack    (irq_ack),
    .irq        (irq),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fire_cnt   (fire_cnt)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d events still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(input int kind, input longint c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d got=0x%0h required=none", kind, cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        miscompares++;
        $display("FAIL event got kind=%0d cyc=%0d val=0x%0h required kind=%0d cyc=%0d val=0x%0h",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  logic [15:0] prev_irq = '0;
  logic        prev_busy = 1'b0;
  bit          init_done = 1'b0;

  always @(negedge ACLK) begin
    if (!init_done) begin
      chk("reset_irq", int'(irq), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_fire_cnt", int'(fire_cnt), 0);
      init_done = 1'b1;
    end
    if (irq !== prev_irq) observe(EV_IRQ, int'(irq));
    prev_irq = irq;
    if (busy !== prev_busy) observe(EV_BUSY, int'({busy, fire_cnt}));
    prev_busy = busy;
    if (done === 1'b1) observe(EV_DONE, int'(fire_cnt));
    if (err === 1'b1) observe(EV_ERR, 0);
    if (end_req) begin
      chk("leftover_expected_events", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic wait_edge(input longint n);
    while (cyc < n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // mode: 0 = run to completion, 1 = abort at k+arel, 2 = reset pulse after edge k+arel
  task automatic run(input logic [15:0] mask, input longint d, input int r, input bit lvl,
                     input int mode, input int arel, input logic [15:0] ack1f, input int min_a);
    ev_t         tl[$];
    ev_t         kept[$];
    logic [15:0] ackat[longint];
    logic [15:0] a;
    logic [15:0] lastirq;
    longint      k, t, c, A, last;
    int          a1, a2, fires;
    k = cyc + 1;
    c = k;
    tl.push_back(mk(EV_BUSY, k, 512));
    for (int i = 0; i <= r; i++) begin
      t = c + d + 1;
      tl.push_back(mk(EV_IRQ, t, int'(mask)));
      if (!lvl) begin
        tl.push_back(mk(EV_IRQ, t + 1, 0));
        c = t + 1;
      end else begin
        a  = (ack1f != '0) ? (ack1f & mask) : (16'($urandom) & mask);
        a1 = $urandom_range(min_a, min_a + 2);
        if (a == '0 || (mask & ~a) == '0) begin
          ackat[t + a1] = mask | (16'($urandom) & ~mask);
          tl.push_back(mk(EV_IRQ, t + a1, 0));
          c = t + a1;
        end else begin
          ackat[t + a1] = a | (16'($urandom) & ~mask);
          tl.push_back(mk(EV_IRQ, t + a1, int'(mask & ~a)));
          a2 = a1 + $urandom_range(1, 3);
          ackat[t + a2] = mask | (16'($urandom) & ~mask);
          tl.push_back(mk(EV_IRQ, t + a2, 0));
          c = t + a2;
        end
      end
    end
    tl.push_back(mk(EV_BUSY, c + 1, r + 1));
    tl.push_back(mk(EV_DONE, c + 1, r + 1));
    last = c + 1;
    A = 0;
    if (mode != 0) begin
      A = k + arel;
      if (A > c) A = c;
      lastirq = '0;
      fires = 0;
      foreach (tl[i]) begin
        if (tl[i].cyc < A) begin
          kept.push_back(tl[i]);
          if (tl[i].kind == EV_IRQ) begin
            lastirq = 16'(tl[i].val);
            if (tl[i].val == int'(mask)) fires++;
          end
        end
      end
      tl = kept;
      if (lastirq != '0) tl.push_back(mk(EV_IRQ, A, 0));
      tl.push_back(mk(EV_BUSY, A, (mode == 1) ? fires : 0));
      last = (mode == 1) ? A : A + 4;
    end
    foreach (tl[i]) exp_q.push_back(tl[i]);

    start      = 1'b1;
    cfg_mask   = mask;
    cfg_delay  = d[31:0];
    cfg_repeat = r[7:0];
    cfg_level  = lvl;
    for (longint n = k + 1; n <= last + 1; n++) begin
      wait_edge(n - 1);
      if (mode == 2 && n - 1 == A) ARESETN = 1'b0;
      if (mode == 2 && n - 1 == A + 3) ARESETN = 1'b1;
      start      = (n == k + 1);
      cfg_mask   = 16'($urandom);
      cfg_delay  = $urandom_range(0, 3);
      cfg_repeat = 8'($urandom);
      cfg_level  = 1'($urandom);
      irq_ack    = ackat.exists(n) ? ackat[n] : (16'($urandom) & ~mask);
      abort      = (mode == 1 && n == A);
    end
    start   = 1'b0;
    abort   = 1'b0;
    irq_ack = '0;
    wait_edge(cyc + longint'($urandom_range(0, 3)));
  endtask

  task automatic err_case(input bit with_abort);
    longint k;
    k = cyc + 1;
    if (!with_abort) exp_q.push_back(mk(EV_ERR, k, 0));
    start     = 1'b1;
    abort     = with_abort;
    cfg_mask  = with_abort ? (16'($urandom) | 16'h0001) : 16'h0000;
    cfg_delay = $urandom_range(0, 3);
    wait_edge(k);
    start = 1'b0;
    abort = 1'b0;
    wait_edge(k + 3);
  endtask

  initial begin
    logic [15:0] m;
    int          sel;
    wait_edge(2);
    ARESETN = 1'b1;
    wait_edge(4);

    run(16'h0005, 3, 2, 1'b0, 0, 0, 16'h0000, 1);
    run(16'h0003, 0, 0, 1'b1, 0, 0, 16'h0001, 1);
    err_case(1'b0);
    run(16'h00F0, 6, 1, 1'b0, 1, 3, 16'h0000, 1);
    run(16'h0C30, 1, 1, 1'b1, 1, 4, 16'h0000, 3);
    run(16'h0C30, 1, 1, 1'b1, 2, 4, 16'h0000, 3);
    run(16'h1234, longint'(32'hFFFF_FFFF), 3, 1'b0, 1, 30, 16'h0000, 1);
    run(16'h8001, 0, 255, 1'b0, 0, 0, 16'h0000, 1);
    err_case(1'b1);

    for (int i = 0; i < 40; i++) begin
      m   = 16'($urandom);
      sel = $urandom_range(0, 19);
      if ($urandom_range(0, 7) == 0) m = '0;
      if (m == '0) begin
        err_case(1'b0);
      end else if (sel == 0) begin
        err_case(1'b1);
      end else begin
        run(m, longint'($urandom_range(0, 5)), $urandom_range(0, 3), 1'($urandom),
            (sel < 14) ? 0 : ((sel < 17) ? 1 : 2), $urandom_range(1, 10), 16'h0000, 1);
      end
    end

    wait_edge(cyc + 10);
    end_req = 1'b1;
  end

endmodule

// File: doc/axi4_pl_irq_sequencer.md
AXI4_PL_IRQ_SEQUENCER -- requirements
Module: axi4_pl_irq_sequencer

Interface
REQ-001 Parameter NUM_IRQ, default 16, number of interrupt lines driven.
REQ-002 Parameter CNT_W, default 32, width of the delay counter.
REQ-003 ACLK  in  1  sole clock; all state updates on rising edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle launch strobe from the register bank.
REQ-006 abort  in  1  single-cycle stop strobe.
REQ-007 cfg_mask  in  NUM_IRQ  lines to fire.
REQ-008 cfg_delay  in  CNT_W  idle cycles before each fire.
REQ-009 cfg_repeat  in  8  additional fires after the first.
REQ-010 cfg_level  in  1  0 = pulse mode, 1 = level mode (hold until ack).
REQ-011 irq_ack  in  NUM_IRQ  per-line acknowledge from the PS side.
REQ-012 irq  out  NUM_IRQ  registered interrupt outputs.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  one-cycle pulse on rejected start.
REQ-016 fire_cnt  out  9  fires issued in the current run.

Function
REQ-017 States: IDLE, WAIT, FIRE, ACK_WAIT, DONE.
REQ-018 IDLE with start=1 and cfg_mask!=0: latch cfg_mask/cfg_delay/cfg_repeat/cfg_level, load counter=cfg_delay, clear fire_cnt, enter WAIT.
REQ-019 IDLE with start=1 and cfg_mask==0: stay IDLE, assert err for one cycle.
REQ-020 Configuration changes after launch have no effect until the next start.
REQ-021 start while busy=1 is ignored, with no err pulse.
REQ-022 WAIT: counter decrements each cycle; when it is 0, the next edge enters FIRE and sets irq to the latched mask.
REQ-023 Start sampled at edge k: irq rises at edge k+cfg_delay+1 (cfg_delay=0 gives a rise at k+1).
REQ-024 fire_cnt increments on the edge that asserts irq.
REQ-025 Pulse mode: irq stays high exactly one cycle, then clears.
REQ-026 Level mode: FIRE goes to ACK_WAIT; each cycle irq <= irq & ~irq_ack; ack bits on deasserted lines are ignored; there is no timeout.
REQ-027 The fire is complete when irq returns to all-zero: the cycle after FIRE in pulse mode, or the cycle after the last ack in level mode.
REQ-028 On completion with remaining repeats > 0: decrement repeats, reload counter=cfg_delay, enter WAIT.
REQ-029 On completion with remaining repeats = 0: enter DONE; done=1 for exactly one cycle; next state is IDLE.
REQ-030 Total fires per run = cfg_repeat+1 (range 1..256); fire_cnt holds its final value until the next accepted start.
REQ-031 abort has the highest priority in any state: next edge clears irq, returns to IDLE, gives no done pulse, and leaves fire_cnt unchanged.
REQ-032 abort and start in the same IDLE cycle: abort wins, start is dropped, no err pulse.
REQ-033 Counter arithmetic is unsigned; the counter never wraps below 0.

Reset
REQ-034 ARESETN low asynchronously forces state=IDLE, irq=0, busy=0, done=0, err=0, fire_cnt=0, counter=0, and all latched configuration to 0.
REQ-035 Reset asserted mid-run discards the run; no done pulse is emitted after release.
REQ-036 Outputs are reset values on the first edge after ARESETN deasserts.

Structure
REQ-037 Package axi4_pl_irq_seq_pkg holds the state enum and the MODE_PULSE/MODE_LEVEL constants.
REQ-038 Sub-module axi4_pl_irq_seq_timer holds the CNT_W loadable down-counter with load, dec and zero outputs.
REQ-039 All outputs are driven from flops, with no combinational input-to-output path.

Verification
REQ-040 Pulse mode, mask=0x0005, delay=3, repeat=2, start at edge k -> irq=0x0005 for one cycle at edges k+4, k+9, k+14; done at k+16; fire_cnt=3.
REQ-041 Level mode, mask=0x0003, delay=0, repeat=0 -> irq=0x0003 at k+1; ack=0x0001 -> irq=0x0002; ack=0x0002 -> irq=0, then done pulse.
REQ-042 start with mask=0 -> err one cycle, busy stays 0, irq stays 0.
REQ-043 Abort in WAIT and abort in ACK_WAIT -> irq=0 and IDLE next edge, no done, fire_cnt retains its count.
REQ-044 ARESETN pulsed low during ACK_WAIT -> all outputs 0 immediately, no done after release.
REQ-045 cfg_delay=0xFFFFFFFF changed to 1 right after start -> the latched delay is still used, with no counter wrap.
